sbox_layer_seq: RTL and testbench

//  Parametrised, folded substitution layer for the encryption datapath.
//  - Applies a 4-bit S-box to every nibble of a DATA_W-bit block.
//  - Processes LANES nibbles per clock over BEATS cycles, trading latency for area.
//  - Supports forward and inverse substitution (per-block mode), so one instance serves encrypt and decrypt.
//  - Sits between round-key mixing and the permutation/rotation stage; valid/ready on both sides.

---
 rtl/sbox_layer_seq.sv | 128 ++++++++++++
 tb/tb_sbox_layer_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_layer_seq
//  Description : Folded 4-bit S-box substitution layer. A block is loaded on
//                accept, LANES nibbles are substituted per cycle over BEATS
//                cycles (forward or inverse per block), then the result is
//                presented with valid/ready until downstream takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_layer_seq #(
   parameter int          DATA_W     = 128,
   parameter int          LANES      = 8,
   parameter logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int c_nibbles = DATA_W / 4;
   localparam int c_beats   = c_nibbles / LANES;
   localparam int c_beat_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
   localparam int c_idx_w   = $clog2(DATA_W);
   localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

   // Inverse table: entry S(i) of the forward table holds value i.
   function automatic logic [63:0] f_invert(input logic [63:0] fwd);
      logic [63:0] inv;
      logic [3:0]  v;
      inv = '0;
      for (int i = 0; i < 16; i++) begin
         v = fwd[6'(i * 4) +: 4];
         inv[{v, 2'b00} +: 4] = 4'(i);
      end
      return inv;
   endfunction

   localparam logic [63:0] c_inv_table = f_invert(SBOX_TABLE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_beat_w-1:0] r_beat;
   logic [DATA_W-1:0]   r_data;
   logic                r_mode;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;

   logic [DATA_W-1:0]   w_data_sub;
   logic [c_idx_w-1:0]  w_bit;
   logic [3:0]          w_nib;

   // Substitute the current beat's LANES nibbles; all other nibbles pass through.
   always_comb begin
      w_data_sub = r_data;
      w_bit      = '0;
      w_nib      = '0;
      for (int l = 0; l < LANES; l++) begin
         w_bit = c_idx_w'((int'(r_beat) * LANES + l) * 4);
         w_nib = r_data[w_bit +: 4];
         w_data_sub[w_bit +: 4] = r_mode ? c_inv_table[{w_nib, 2'b00} +: 4]
                                         : SBOX_TABLE[{w_nib, 2'b00} +: 4];
      end
   end

   // Control FSM and datapath registers; the result register is only written
   // on the final beat, so a partially substituted block never reaches out_data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_data      <= '0;
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_data  <= in_data;
                  r_mode  <= in_inv;
                  r_beat  <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_data <= w_data_sub;
               if (r_beat == c_last_beat) begin
                  r_beat      <= '0;
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_data_sub;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbox_layer_seq
//  Description : Directed self-checking bench for sbox_layer_seq (LANES=8 and
//                LANES=32 builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_layer_seq;

   localparam int DATA_W = 128;
   localparam logic [127:0] c_zero_out = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
   localparam logic [127:0] c_pat     = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] c_pat_fwd = 128'hC56B90AD3EF84712C56B90AD3EF84712;
   localparam logic [127:0] c_all_f   = {32{4'hF}};
   localparam logic [127:0] c_all_2   = {32{4'h2}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              in_valid, in_ready, in_inv, out_valid, out_ready, busy;
   logic [DATA_W-1:0] in_data, out_data;
   logic              in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b, busy_b;
   logic [DATA_W-1:0] in_data_b, out_data_b;

   int tests  = 0;
   int failed = 0;

   sbox_layer_seq #(.DATA_W(DATA_W), .LANES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   sbox_layer_seq #(.DATA_W(DATA_W), .LANES(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_inv(in_inv_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
   );

   // Present one block on the LANES=8 instance and count edges after the accept
   // edge until out_valid is seen (sampled 1 time unit after each edge).
   task automatic run8(input logic [127:0] d, input logic inv, output int lat);
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (out_data !== '0) begin failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      tests++; if (in_ready_b !== 1'b1) begin failed++; $display("FAIL reset_in_ready32 got %b want 1", in_ready_b); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fwd_zero();
      int lat;
      out_ready = 1'b1;
      run8('0, 1'b0, lat);
      // out_valid seen after edge 4 means it is high at edge accept+5
      tests++; if (lat !== 4) begin failed++; $display("FAIL fwd_zero_latency got %0d want 4", lat); end
      tests++; if (out_data !== c_zero_out) begin failed++; $display("FAIL fwd_zero_data got %h want %h", out_data, c_zero_out); end
      tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failed++; $display("FAIL fwd_zero_done_flags got busy=%b in_ready=%b want 1/0", busy, in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL fwd_zero_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      tests++; if (out_data !== c_zero_out) begin failed++; $display("FAIL fwd_zero_hold_data got %h want %h", out_data, c_zero_out); end
   endtask

   task automatic test_fwd_pattern();
      int lat;
      out_ready = 1'b1;
      run8(c_pat, 1'b0, lat);
      tests++; if (lat !== 4) begin failed++; $display("FAIL fwd_pat_latency got %0d want 4", lat); end
      tests++; if (out_data !== c_pat_fwd) begin failed++; $display("FAIL fwd_pat_data got %h want %h", out_data, c_pat_fwd); end
      @(posedge clk); #1;
   endtask

   task automatic test_inverse();
      int lat;
      out_ready = 1'b1;
      run8(c_pat_fwd, 1'b1, lat);
      tests++; if (lat !== 4) begin failed++; $display("FAIL inv_latency got %0d want 4", lat); end
      tests++; if (out_data !== c_pat) begin failed++; $display("FAIL inv_data got %h want %h", out_data, c_pat); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int  lat;
      int  bad;
      out_ready = 1'b0;
      run8(c_pat, 1'b0, lat);
      tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL bp_reach_done got valid=%b want 1", out_valid); end
      // offer a new block while stalled; it must not be taken
      in_data  = c_pat_fwd;
      in_inv   = 1'b1;
      in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_data !== c_pat_fwd || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      tests++; if (bad !== 0) begin failed++; $display("FAIL bp_hold_stable got %0d bad cycles want 0 (data %h)", bad, out_data); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failed++; $display("FAIL bp_release got in_ready=%b valid=%b want 1/0", in_ready, out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL bp_next_accept got in_ready=%b busy=%b want 0/1", in_ready, busy); end
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++; if (lat !== 4) begin failed++; $display("FAIL bp_next_latency got %0d want 4", lat); end
      tests++; if (out_data !== c_pat) begin failed++; $display("FAIL bp_next_data got %h want %h", out_data, c_pat); end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int seen;
      out_ready = 1'b1;
      in_data   = c_all_f;
      in_inv    = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;            // accept edge
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end   // beat counter now 2
      tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failed++; $display("FAIL rst_run_pre got busy=%b valid=%b want 1/0", busy, out_valid); end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_run_valid got %b want 0", out_valid); end
      tests++; if (out_data !== '0) begin failed++; $display("FAIL rst_run_data got %h want 0", out_data); end
      tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL rst_run_flags got busy=%b in_ready=%b want 0/1", busy, in_ready); end
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
      tests++; if (seen !== 0) begin failed++; $display("FAIL rst_run_no_output got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_lanes32();
      int lat;
      out_ready_b = 1'b1;
      in_data_b   = c_all_f;
      in_inv_b    = 1'b0;
      in_valid_b  = 1'b1;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      lat = 0;
      while (!out_valid_b && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      // seen after edge 1 means high at edge accept+2
      tests++; if (lat !== 1) begin failed++; $display("FAIL l32_latency got %0d want 1", lat); end
      tests++; if (out_data_b !== c_all_2) begin failed++; $display("FAIL l32_data got %h want %h", out_data_b, c_all_2); end
      @(posedge clk); #1;
      tests++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin failed++; $display("FAIL l32_release got valid=%b in_ready=%b want 0/1", out_valid_b, in_ready_b); end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      in_inv      = 1'b0;
      out_ready   = 1'b0;
      in_valid_b  = 1'b0;
      in_data_b   = '0;
      in_inv_b    = 1'b0;
      out_ready_b = 1'b0;
      #1;
      test_reset();
      test_fwd_zero();
      test_fwd_pattern();
      test_inverse();
      test_back_to_back();
      test_reset_mid_run();
      test_lanes32();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
